// File: rtl/tensor_core_register_readback.sv
// Streams a snapshot of the tensor core register file, one byte per beat, over valid/ready.
// The parallel read bus is captured on start so later register writes cannot disturb a dump.
module tensor_core_register_readback #(
    parameter int NUMBER_OF_REGISTERS = 32,
    localparam int M = (NUMBER_OF_REGISTERS - 1) / 16 + 1,
    localparam int A = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                        clock_in,
    input  logic                        reset_in,
    input  logic                        start_in,
    input  logic [A-1:0]                start_address_in,
    input  logic [A:0]                  count_in,
    input  logic [M-1:0][3:0][3:0][7:0] register_data_in,
    output logic [7:0]                  data_out,
    output logic [A-1:0]                address_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        last_out,
    output logic                        busy_out,
    output logic                        done_out
);

    localparam int N      = NUMBER_OF_REGISTERS;
    localparam int FLAT_W = M * 128;
    localparam int IW     = $clog2(FLAT_W);
    localparam logic [A-1:0] LAST_ADDR = A'(N - 1);
    localparam logic [A:0]   N_COUNT   = (A + 1)'(N);

    // Handshake: a beat transfers on any rising edge where valid_out and ready_in are both
    // high; while valid_out is high and ready_in is low, data/address/last hold steady.

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [M-1:0][3:0][3:0][7:0]   snapshot_q, snapshot_d;
    logic [A-1:0]                  addr_q, addr_d;
    logic [A:0]                    remaining_q, remaining_d;
    logic [7:0]                    data_q, data_d;
    logic                          valid_q, valid_d;
    logic                          last_q, last_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic [A-1:0] start_mod;
    logic [A:0]   count_clamped;
    logic [A-1:0] next_addr;

    // Register r lives at [r/16][(r%16)/4][r%4], which is byte r of the flattened bus.
    function automatic logic [7:0] read_byte(input logic [FLAT_W-1:0] flat,
                                             input logic [A-1:0]      addr);
        logic [IW-1:0] base;
        base = IW'({addr, 3'b000});
        return flat[base +: 8];
    endfunction

    // start_address_in is below 2^A < 2N, so one conditional subtraction reduces it mod N.
    assign start_mod     = (start_address_in > LAST_ADDR) ? start_address_in - A'(N)
                                                          : start_address_in;
    assign count_clamped = (count_in > N_COUNT) ? N_COUNT : count_in;
    assign next_addr     = (addr_q == LAST_ADDR) ? '0 : addr_q + A'(1);

    always_comb begin
        state_d     = state_q;
        snapshot_d  = snapshot_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                if (start_in) begin
                    snapshot_d  = register_data_in;
                    addr_d      = start_mod;
                    remaining_d = count_clamped;
                    busy_d      = 1'b1;
                    if (count_clamped == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // First beat comes straight off the bus; the snapshot is not loaded yet.
                        state_d = ST_STREAM;
                        valid_d = 1'b1;
                        last_d  = (count_clamped == (A + 1)'(1));
                        data_d  = read_byte(register_data_in, start_mod);
                    end
                end
            end
            ST_STREAM: begin
                if (ready_in) begin
                    if (remaining_q == (A + 1)'(1)) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d      = next_addr;
                        remaining_d = remaining_q - (A + 1)'(1);
                        data_d      = read_byte(snapshot_q, next_addr);
                        last_d      = (remaining_q == (A + 1)'(2));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            snapshot_q  <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snapshot_q  <= snapshot_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign data_out    = data_q;
    assign address_out = addr_q;
    assign valid_out   = valid_q;
    assign last_out    = last_q;
    assign busy_out    = busy_q;
    assign done_out    = done_q;

endmodule

// File: tb/tb_tensor_core_register_readback.sv
// Bench for tensor_core_register_readback: a 32-register and a 20-register instance share
// stimulus; each is checked every cycle against a beat-list model of the dump.
module tb_tensor_core_register_readback;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [4:0] sa;
    logic [5:0] cnt;
    logic ready;
    logic rand_ready;
    logic [7:0] regs[32];
    logic [1:0][3:0][3:0][7:0] rf_bus;

    logic [7:0] d_o[2];
    logic [4:0] a_o[2];
    logic       v_o[2];
    logic       l_o[2];
    logic       b_o[2];
    logic       dn_o[2];

    int checks = 0;
    int errors = 0;

    // Model: the list of beats still owed, plus a flag for the done cycle.
    int m_addr[2][32];
    int m_data[2][32];
    int m_head[2];
    int m_len[2];
    bit m_done[2];

    // Log of what each DUT actually transferred, for hand-computed literal checks.
    int log_addr[2][64];
    int log_data[2][64];
    bit log_last[2][64];
    int log_n[2];
    int done_n[2];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 32; i++) rf_bus[i / 16][(i % 16) / 4][i % 4] = regs[i];
    end

    tensor_core_register_readback #(.NUMBER_OF_REGISTERS(32)) dut32 (
        .clock_in(clk), .reset_in(rst), .start_in(start), .start_address_in(sa),
        .count_in(cnt), .register_data_in(rf_bus), .data_out(d_o[0]), .address_out(a_o[0]),
        .valid_out(v_o[0]), .ready_in(ready), .last_out(l_o[0]), .busy_out(b_o[0]),
        .done_out(dn_o[0])
    );

    tensor_core_register_readback #(.NUMBER_OF_REGISTERS(20)) dut20 (
        .clock_in(clk), .reset_in(rst), .start_in(start), .start_address_in(sa),
        .count_in(cnt), .register_data_in(rf_bus), .data_out(d_o[1]), .address_out(a_o[1]),
        .valid_out(v_o[1]), .ready_in(ready), .last_out(l_o[1]), .busy_out(b_o[1]),
        .done_out(dn_o[1])
    );

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual %0h required %0h", name, k, $time, act, exp_v);
        end
    endtask

    // Model update at each edge, from the inputs the DUT sees at that edge.
    always @(posedge clk or posedge rst) begin
        int nn, n, s;
        for (int k = 0; k < 2; k++) begin
            nn = (k == 0) ? 32 : 20;
            if (rst) begin
                m_head[k] = 0;
                m_len[k]  = 0;
                m_done[k] = 1'b0;
            end else if (m_done[k]) begin
                m_done[k] = 1'b0;
            end else if (m_len[k] > 0) begin
                if (ready) begin
                    m_head[k]++;
                    m_len[k]--;
                    if (m_len[k] == 0) m_done[k] = 1'b1;
                end
            end else if (start) begin
                n = (int'(cnt) > nn) ? nn : int'(cnt);
                s = int'(sa) % nn;
                for (int i = 0; i < n; i++) begin
                    m_addr[k][i] = (s + i) % nn;
                    m_data[k][i] = int'(regs[(s + i) % nn]);
                end
                m_head[k] = 0;
                m_len[k]  = n;
                if (n == 0) m_done[k] = 1'b1;
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                check("rst_valid", k, 32'(v_o[k]), 0);
                check("rst_last", k, 32'(l_o[k]), 0);
                check("rst_busy", k, 32'(b_o[k]), 0);
                check("rst_done", k, 32'(dn_o[k]), 0);
                check("rst_data", k, 32'(d_o[k]), 0);
                check("rst_addr", k, 32'(a_o[k]), 0);
            end else begin
                check("valid", k, 32'(v_o[k]), 32'(m_len[k] > 0));
                check("last", k, 32'(l_o[k]), 32'(m_len[k] == 1));
                check("busy", k, 32'(b_o[k]), 32'((m_len[k] > 0) || m_done[k]));
                check("done", k, 32'(dn_o[k]), 32'(m_done[k]));
                if (m_len[k] > 0) begin
                    check("data", k, 32'(d_o[k]), 32'(m_data[k][m_head[k]]));
                    check("addr", k, 32'(a_o[k]), 32'(m_addr[k][m_head[k]]));
                end
                if (v_o[k] && ready && log_n[k] < 64) begin
                    log_addr[k][log_n[k]] = int'(a_o[k]);
                    log_data[k][log_n[k]] = int'(d_o[k]);
                    log_last[k][log_n[k]] = l_o[k];
                    log_n[k]++;
                end
                if (dn_o[k]) done_n[k]++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int s, input int c);
        tick(1);
        start = 1'b1;
        sa    = 5'(s);
        cnt   = 6'(c);
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (((m_len[0] > 0) || m_done[0] || (m_len[1] > 0) || m_done[1]) && budget < 300) begin
            tick(1);
            budget++;
        end
        checks++;
        if (budget >= 300) begin
            errors++;
            $display("FAIL idle_timeout actual %0d cycles required below 300", budget);
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            log_n[k]  = 0;
            done_n[k] = 0;
        end
    endtask

    task automatic pattern_regs();
        for (int i = 0; i < 32; i++) regs[i] = 8'(i + 1);
    endtask

    initial begin
        int e_addr[4];
        int e_data[4];
        rst = 1'b1;
        start = 1'b0;
        sa = '0;
        cnt = '0;
        ready = 1'b1;
        rand_ready = 1'b0;
        pattern_regs();
        clear_logs();
        tick(3);
        rst = 1'b0;

        // Full dump of 32 registers.
        clear_logs();
        do_start(0, 32);
        wait_idle();
        check("full_n", 0, log_n[0], 32);
        check("full_first_data", 0, log_data[0][0], 1);
        check("full_last_data", 0, log_data[0][31], 32);
        check("full_last_addr", 0, log_addr[0][31], 31);
        check("full_last_flag", 0, 32'(log_last[0][31]), 1);
        check("full_prelast_flag", 0, 32'(log_last[0][30]), 0);
        check("full_done_n", 0, done_n[0], 1);
        check("full_n", 1, log_n[1], 20);

        // Wrapping range.
        clear_logs();
        do_start(30, 4);
        wait_idle();
        e_addr = '{30, 31, 0, 1};
        e_data = '{31, 32, 1, 2};
        check("wrap_n", 0, log_n[0], 4);
        for (int i = 0; i < 4; i++) begin
            check("wrap_addr", 0, log_addr[0][i], e_addr[i]);
            check("wrap_data", 0, log_data[0][i], e_data[i]);
            check("wrap_last", 0, 32'(log_last[0][i]), 32'(i == 3));
        end

        // Backpressure.
        clear_logs();
        rand_ready = 1'b1;
        do_start(5, 16);
        wait_idle();
        rand_ready = 1'b0;
        check("bp_n", 0, log_n[0], 16);
        check("bp_n", 1, log_n[1], 16);
        check("bp_addr15", 1, log_addr[1][15], 0);
        check("bp_data15", 0, log_data[0][15], 21);

        // Snapshot isolation.
        clear_logs();
        do_start(0, 32);
        tick(6);
        for (int i = 0; i < 32; i++) regs[i] = 8'hFF;
        wait_idle();
        check("iso_data20", 0, log_data[0][20], 21);
        check("iso_data31", 0, log_data[0][31], 32);
        pattern_regs();

        // Empty dump.
        clear_logs();
        do_start(7, 0);
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            check("empty_n", k, log_n[k], 0);
            check("empty_done_n", k, done_n[k], 1);
        end

        // Count clamped.
        clear_logs();
        do_start(0, 40);
        wait_idle();
        check("clamp_n", 0, log_n[0], 32);
        check("clamp_n", 1, log_n[1], 20);

        // Start pulsed mid-stream is ignored.
        clear_logs();
        do_start(0, 32);
        tick(4);
        start = 1'b1;
        sa = 5'd9;
        cnt = 6'd3;
        tick(1);
        start = 1'b0;
        wait_idle();
        check("ign_n", 0, log_n[0], 32);
        check("ign_first_addr", 0, log_addr[0][0], 0);
        check("ign_done_n", 0, done_n[0], 1);

        // N=20 wrap at a non-multiple of 16.
        clear_logs();
        do_start(18, 4);
        wait_idle();
        e_addr = '{18, 19, 0, 1};
        e_data = '{19, 20, 1, 2};
        check("n20_n", 1, log_n[1], 4);
        for (int i = 0; i < 4; i++) begin
            check("n20_addr", 1, log_addr[1][i], e_addr[i]);
            check("n20_data", 1, log_data[1][i], e_data[i]);
        end

        // Randomized dumps with random contents, backpressure and mid-dump writes.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = 8'($urandom);
            rand_ready = 1'($urandom_range(0, 1));
            do_start(int'($urandom_range(0, 31)), int'($urandom_range(0, 40)));
            tick(int'($urandom_range(1, 8)));
            regs[$urandom_range(0, 31)] = 8'($urandom);
            wait_idle();
        end
        rand_ready = 1'b0;
        pattern_regs();

        // Reset mid-dump, then a normal 2-beat dump.
        clear_logs();
        do_start(0, 32);
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("abort_valid", k, 32'(v_o[k]), 0);
            check("abort_busy", k, 32'(b_o[k]), 0);
            check("abort_done", k, 32'(dn_o[k]), 0);
        end
        tick(1);
        rst = 1'b0;
        clear_logs();
        do_start(3, 2);
        wait_idle();
        check("post_rst_n", 0, log_n[0], 2);
        check("post_rst_addr0", 0, log_addr[0][0], 3);
        check("post_rst_data1", 0, log_data[0][1], 5);
        check("post_rst_last1", 0, 32'(log_last[0][1]), 1);
        check("post_rst_n", 1, log_n[1], 2);
        check("post_rst_done_n", 0, done_n[0], 1);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual %0t required finish before 300000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tensor_core_register_readback.md
# tensor_core_register_readback

Streams the contents of the tensor core register file out one 8-bit register per beat over a valid/ready interface. Used for host readback, debug dumps and result draining. On a start request it snapshots the register file's full parallel read bus, so later register file writes cannot corrupt a dump in progress. It then serializes a contiguous, wrapping address range, tagging each beat with its register address and a last flag.

## Interface
Parameters:
- NUMBER_OF_REGISTERS, 32, registers in the attached register file; M = (NUMBER_OF_REGISTERS-1)/16 + 1 matrices of 4x4; A = $clog2(NUMBER_OF_REGISTERS)

Ports:
- clock_in  input  1  single clock, all logic on rising edge
- reset_in  input  1  asynchronous, active-high reset
- start_in  input  1  request a dump; sampled only in IDLE
- start_address_in  input  A  first register address; reduced modulo NUMBER_OF_REGISTERS
- count_in  input  A+1  registers to stream; clamped to NUMBER_OF_REGISTERS; 0 = empty dump
- register_data_in  input  8 x [M][4][4]  parallel read bus from the register file
- data_out  output  8  streamed register value
- address_out  output  A  address of the current data_out
- valid_out  output  1  data_out/address_out/last_out valid
- ready_in  input  1  consumer accepts the beat
- last_out  output  1  current beat is the final beat of the dump
- busy_out  output  1  high in CAPTURE-done-through-STREAM (states STREAM and DONE)
- done_out  output  1  one-cycle pulse after the final beat transfers

## Operation
- States: IDLE, STREAM, DONE.
- IDLE:
  - On start_in=1, capture all of register_data_in into an internal snapshot.
  - Latch the start address modulo N and the remaining count min(count_in, N).
  - If the clamped count is 0, go to DONE. Otherwise go to STREAM.
- STREAM:
  - valid_out=1.
  - data_out = snapshot[addr/16][(addr%16)/4][addr%4].
  - last_out=1 when the remaining count is 1.
  - Transfer occurs on a cycle with valid_out & ready_in. Each transfer decrements the remaining count and advances the address by 1, wrapping from N-1 to 0.
  - A transfer with last_out=1 moves to DONE.
- DONE: done_out=1 for exactly one cycle, busy_out=1. Next state is IDLE.
- start_in is ignored outside IDLE, with no queuing.
- Snapshot contents change only at capture. Register file writes during STREAM do not affect streamed data.
- While valid_out=1 and ready_in=0, data_out, address_out and last_out are held stable.
- valid_out never drops until the beat transfers.
- Address arithmetic is modulo NUMBER_OF_REGISTERS. Addresses at or above N are never emitted, including when N is not a multiple of 16.

## Timing
- Reset values (asynchronous, immediate): state IDLE, valid_out=0, last_out=0, busy_out=0, done_out=0, data_out=0, address_out=0. The snapshot is cleared to 0.
- Start accepted at edge T: valid_out=1 and first beat presented after T; the first transfer can occur at edge T+1.
- Throughput: one beat per cycle with ready_in held at 1. A dump of K beats has its last transfer at edge T+K, done_out is high during the cycle after that, and IDLE is reached one cycle later.
- Empty dump (count 0): done_out is high the cycle after the start edge, with no valid_out.
- Minimum spacing between accepted starts: K+2 cycles.
- Reset asserted mid-dump:
  - aborts immediately;
  - no done_out;
  - no further beats;
  - the first start after reset release behaves normally.
- No combinational path from ready_in or start_in to any output. All outputs are registered.

## Test plan
- Reset with N=32; write register r with value r+1; start with address 0, count 32, ready_in=1 -> 32 consecutive beats with data 1..32, addresses 0..31, last_out on address 31, done_out pulse one cycle later.
- Start with address 30, count 4 -> addresses 30,31,0,1 with data 31,32,1,2; last_out only on address 1.
- Backpressure: toggle ready_in pseudo-randomly during a 16-beat dump -> no beat lost or duplicated; outputs stable while stalled; beat order unchanged.
- Snapshot isolation: start the dump, then bulk-write all registers to 0xFF mid-stream -> every streamed value equals the pre-start contents.
- Boundaries: count 0 -> done_out with no valid_out; count 40 -> exactly 32 beats; start_in pulsed during STREAM -> ignored; with N=20, start at address 18, count 4 -> addresses 18,19,0,1.
- Reset mid-dump at beat 5 -> valid_out, busy_out and done_out drop to 0 immediately; a new start of 2 beats completes correctly.
